frame_signed_minmax: RTL and testbench



---
 rtl/frame_signed_minmax_pkg.sv | 8 +
 rtl/frame_signed_minmax_if.sv | 32 +++
 rtl/frame_signed_minmax_cmp.sv | 10 +
 rtl/frame_signed_minmax.sv | 102 ++++++++++
 tb/tb_frame_signed_minmax.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/frame_signed_minmax_pkg.sv
// Shared types and default sizing for the frame min/max reduction stage.
package minmax_pkg;
    typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

    localparam int DEF_W     = 32;
    localparam int DEF_CNT_W = 16;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/frame_signed_minmax_if.sv
// Sample-in / result-out handshake bundle; slave is the reduction stage's view.
interface frame_signed_minmax_if
    import minmax_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_min;
    logic [W-1:0]     out_max;
    logic [CNT_W-1:0] out_min_idx;
    logic [CNT_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max,
               out_min_idx, out_max_idx, out_count, out_sat
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max,
               out_min_idx, out_max_idx, out_count, out_sat
    );
endinterface

// File: rtl/frame_signed_minmax_cmp.sv
// Combinational strict two's-complement less-than: lt = (a < b).
module signed_lt_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
    assign lt = $signed(a) < $signed(b);
endmodule

// File: rtl/frame_signed_minmax.sv
// Per-frame running min/max reduction; emits one registered result beat at frame end.
module frame_signed_minmax
    import minmax_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frame_signed_minmax_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIM = '1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_min, r_max;
    logic [CNT_W-1:0] r_min_idx, r_max_idx, r_count;
    logic             r_sat;

    logic             w_lt_min, w_gt_max, w_acc, w_full;
    logic [CNT_W-1:0] w_cnt_nxt;

    signed_lt_cmp #(.W(W)) u_lt_min (.a(bus.in_data), .b(r_min),       .lt(w_lt_min));
    signed_lt_cmp #(.W(W)) u_gt_max (.a(r_max),       .b(bus.in_data), .lt(w_gt_max));

    assign w_acc     = bus.in_valid & r_in_ready;
    assign w_full    = (r_count == LIM);
    assign w_cnt_nxt = w_full ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_min       <= '0;
            r_max       <= '0;
            r_min_idx   <= '0;
            r_max_idx   <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_acc) begin
                        r_min       <= bus.in_data;
                        r_max       <= bus.in_data;
                        r_min_idx   <= '0;
                        r_max_idx   <= '0;
                        r_count     <= CNT_W'(1);
                        r_sat       <= 1'b0;
                        r_state     <= bus.in_last ? HOLD : ACCUM;
                        r_in_ready  <= ~bus.in_last;
                        r_out_valid <= bus.in_last;
                    end
                end
                ACCUM: begin
                    if (w_acc) begin
                        // r_count is this sample's index; pinned at LIM once saturated
                        if (w_lt_min) begin
                            r_min     <= bus.in_data;
                            r_min_idx <= r_count;
                        end
                        if (w_gt_max) begin
                            r_max     <= bus.in_data;
                            r_max_idx <= r_count;
                        end
                        r_count <= w_cnt_nxt;
                        if (w_full) r_sat <= 1'b1;
                        if (bus.in_last) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_min     = r_min;
    assign bus.out_max     = r_max;
    assign bus.out_min_idx = r_min_idx;
    assign bus.out_max_idx = r_max_idx;
    assign bus.out_count   = r_count;
    assign bus.out_sat     = r_sat;
endmodule

// File: tb/tb_frame_signed_minmax.sv
// Directed bench: 32-bit/16-bit-count instance plus a 4-bit-count instance for saturation.
module tb_frame_signed_minmax;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    frame_signed_minmax_if #(.W(32), .CNT_W(16)) b32 ();
    frame_signed_minmax_if #(.W(32), .CNT_W(4))  b4 ();

    frame_signed_minmax #(.W(32), .CNT_W(16)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    frame_signed_minmax #(.W(32), .CNT_W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    task automatic drive(input bit sel, input logic v, input logic [31:0] d, input logic l);
        if (sel) begin b4.in_valid = v; b4.in_data = d; b4.in_last = l; end
        else     begin b32.in_valid = v; b32.in_data = d; b32.in_last = l; end
    endtask

    // Present one sample and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] d, input logic l);
        bit done = 0;
        drive(sel, 1'b1, d, l);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if ((sel ? b4.in_ready : b32.in_ready) === 1'b1) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        drive(sel, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_timeout: in_ready never seen, sel=%0d data=%h", sel, d);
        end
    endtask

    // Pulse out_ready across one edge; result beat must then be gone.
    task automatic take(input bit sel);
        @(negedge clk);
        if (sel) b4.out_ready = 1'b1; else b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0; b32.out_ready = 1'b0;
        n_cmp++;
        if ((sel ? b4.out_valid : b32.out_valid) !== 1'b0) begin
            n_bad++;
            $display("FAIL take_drop: out_valid=%b required 0", sel ? b4.out_valid : b32.out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (b32.in_ready !== 1'b0)    begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", b32.in_ready); end
        n_cmp++; if (b32.out_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.out_min !== 32'h0 || b32.out_max !== 32'h0) begin n_bad++; $display("FAIL rst_minmax: got %h/%h want 0/0", b32.out_min, b32.out_max); end
        n_cmp++; if (b32.out_count !== 16'h0 || b32.out_min_idx !== 16'h0 || b32.out_max_idx !== 16'h0) begin n_bad++; $display("FAIL rst_cnt_idx: got %h/%h/%h want 0", b32.out_count, b32.out_min_idx, b32.out_max_idx); end
        n_cmp++; if (b32.out_sat !== 1'b0)     begin n_bad++; $display("FAIL rst_sat: got %b want 0", b32.out_sat); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_cmp++; if (b32.in_ready !== 1'b0)    begin n_bad++; $display("FAIL rst_release_ready: got %b want 0 before first edge", b32.in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (b32.in_ready !== 1'b1)    begin n_bad++; $display("FAIL rst_first_edge_ready: got %b want 1", b32.in_ready); end
    endtask

    task automatic test_single();
        send(0, 32'hFFFF_FFFE, 1'b1);
        n_cmp++; if (b32.out_valid !== 1'b1)   begin n_bad++; $display("FAIL single_latency: out_valid=%b want 1", b32.out_valid); end
        n_cmp++; if (b32.out_min !== 32'hFFFF_FFFE || b32.out_max !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL single_minmax: got %h/%h want fffffffe", b32.out_min, b32.out_max); end
        n_cmp++; if (b32.out_min_idx !== 16'd0 || b32.out_max_idx !== 16'd0 || b32.out_count !== 16'd1) begin n_bad++; $display("FAIL single_idx_cnt: got %0d/%0d/%0d want 0/0/1", b32.out_min_idx, b32.out_max_idx, b32.out_count); end
        n_cmp++; if (b32.in_ready !== 1'b0)    begin n_bad++; $display("FAIL single_hold_ready: got %b want 0", b32.in_ready); end
        take(0);
    endtask

    task automatic test_ties();
        logic [31:0] v [5];
        v = '{32'd5, -32'sd3, 32'd7, -32'sd3, 32'd7};
        for (int i = 0; i < 5; i++) send(0, v[i], i == 4);
        n_cmp++; if (b32.out_min !== 32'hFFFF_FFFD || b32.out_min_idx !== 16'd1) begin n_bad++; $display("FAIL ties_min: got %h@%0d want fffffffd@1", b32.out_min, b32.out_min_idx); end
        n_cmp++; if (b32.out_max !== 32'd7 || b32.out_max_idx !== 16'd2) begin n_bad++; $display("FAIL ties_max: got %h@%0d want 7@2", b32.out_max, b32.out_max_idx); end
        n_cmp++; if (b32.out_count !== 16'd5 || b32.out_sat !== 1'b0) begin n_bad++; $display("FAIL ties_count: got %0d sat %b want 5 sat 0", b32.out_count, b32.out_sat); end
        take(0);
    endtask

    task automatic test_extremes();
        send(0, 32'h0000_0000, 1'b0);
        send(0, 32'h8000_0000, 1'b0);
        send(0, 32'h7FFF_FFFF, 1'b1);
        n_cmp++; if (b32.out_min !== 32'h8000_0000 || b32.out_min_idx !== 16'd1) begin n_bad++; $display("FAIL ext_min: got %h@%0d want 80000000@1", b32.out_min, b32.out_min_idx); end
        n_cmp++; if (b32.out_max !== 32'h7FFF_FFFF || b32.out_max_idx !== 16'd2) begin n_bad++; $display("FAIL ext_max: got %h@%0d want 7fffffff@2", b32.out_max, b32.out_max_idx); end
        n_cmp++; if (b32.out_count !== 16'd3) begin n_bad++; $display("FAIL ext_count: got %0d want 3", b32.out_count); end
        take(0);
    endtask

    task automatic test_backpressure();
        int bad_cycles = 0;
        send(0, 32'd1, 1'b0);
        send(0, 32'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1 || b32.out_min !== 32'd1 ||
                b32.out_max !== 32'd2 || b32.out_count !== 16'd2 || b32.out_max_idx !== 16'd1)
                bad_cycles++;
        end
        n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad_cycles); end
        take(0);
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_turnaround_ready: got %b want 1", b32.in_ready); end
        send(0, 32'hFFFF_FF00, 1'b1);
        n_cmp++; if (b32.out_valid !== 1'b1 || b32.out_min !== 32'hFFFF_FF00 || b32.out_count !== 16'd1) begin n_bad++; $display("FAIL bp_next_frame: vld %b min %h cnt %0d want 1/ffffff00/1", b32.out_valid, b32.out_min, b32.out_count); end
        take(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) send(1, (i == 18) ? 32'd100 : 32'd0, i == 19);
        n_cmp++; if (b4.out_count !== 4'd15 || b4.out_sat !== 1'b1) begin n_bad++; $display("FAIL sat_count: got %0d sat %b want 15 sat 1", b4.out_count, b4.out_sat); end
        n_cmp++; if (b4.out_max !== 32'd100 || b4.out_max_idx !== 4'd15) begin n_bad++; $display("FAIL sat_max: got %0d@%0d want 100@15", b4.out_max, b4.out_max_idx); end
        n_cmp++; if (b4.out_min !== 32'd0 || b4.out_min_idx !== 4'd0) begin n_bad++; $display("FAIL sat_min: got %0d@%0d want 0@0", b4.out_min, b4.out_min_idx); end
        take(1);
        for (int i = 0; i < 15; i++) send(1, 32'd3, i == 14);
        n_cmp++; if (b4.out_count !== 4'd15 || b4.out_sat !== 1'b0) begin n_bad++; $display("FAIL sat_exact15: got %0d sat %b want 15 sat 0", b4.out_count, b4.out_sat); end
        take(1);
    endtask

    task automatic test_reset_midframe();
        send(0, 32'd1, 1'b0);
        send(0, -32'sd100, 1'b0);
        send(0, 32'd200, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        n_cmp++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_flush: vld %b rdy %b want 0/0", b32.out_valid, b32.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        send(0, 32'd9, 1'b0);
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_partial: out_valid %b want 0", b32.out_valid); end
        send(0, 32'd4, 1'b1);
        n_cmp++; if (b32.out_min !== 32'd4 || b32.out_min_idx !== 16'd1) begin n_bad++; $display("FAIL midrst_min: got %0d@%0d want 4@1", b32.out_min, b32.out_min_idx); end
        n_cmp++; if (b32.out_max !== 32'd9 || b32.out_max_idx !== 16'd0) begin n_bad++; $display("FAIL midrst_max: got %0d@%0d want 9@0", b32.out_max, b32.out_max_idx); end
        n_cmp++; if (b32.out_count !== 16'd2 || b32.out_sat !== 1'b0) begin n_bad++; $display("FAIL midrst_count: got %0d sat %b want 2 sat 0", b32.out_count, b32.out_sat); end
        take(0);
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_last = 1'b0; b32.out_ready = 1'b0;
        b4.in_valid  = 1'b0; b4.in_data  = '0; b4.in_last  = 1'b0; b4.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_ties();
        test_extremes();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
